// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: helpers shared by the FIFO controller and its reference model.
// Holds no per-instance parameters; every size comes from the instantiating module.
package fifo_sync_pkg;

  // Number of words addressed by an awidth-bit pointer.
  function automatic int depth(int awidth);
    return 1 << awidth;
  endfunction

  // Occupancy after one cycle, given which requests were actually accepted.
  function automatic int unsigned usedw_next(int unsigned usedw, logic wr_acc, logic rd_acc);
    if (wr_acc && !rd_acc) return usedw + 1;
    if (rd_acc && !wr_acc) return usedw - 1;
    return usedw;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// ram_memory: simple dual-port RAM, one write port and one registered read port.
// Contents are not reset. A read of the address being written returns the old word.
module ram_memory #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic [DWIDTH-1:0] data,
  input  logic              wren,
  input  logic [AWIDTH-1:0] wrpntr,
  input  logic [AWIDTH-1:0] rdpntr,
  output logic [DWIDTH-1:0] q
);

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];

  // Write port plus registered read port; the read samples the array before this edge's write.
  always_ff @(posedge clk) begin
    if (wren) r_mem[wrpntr] <= data;
    q <= r_mem[rdpntr];
  end

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO controller around ram_memory.
// Owns pointers, occupancy counter and registered status flags.
// Define FIFO_SYNC_SHOWAHEAD_EN for show-ahead (first-word-fall-through) output;
// by default q_o presents the word fetched by the last accepted read.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 4,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o
);

  localparam int DEPTH = depth(AWIDTH);
  localparam int UW    = AWIDTH + 1;

  logic [AWIDTH-1:0] r_wrptr;
  logic [AWIDTH-1:0] r_rdptr;
  logic [AWIDTH-1:0] w_rdptr_nxt;
  logic [AWIDTH-1:0] w_rdpntr;
  logic [UW-1:0]     r_usedw;
  logic [UW-1:0]     w_usedw_nxt;
  logic              r_full;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DWIDTH-1:0] w_ram_q;

  // Flags are judged on the registered state, so a full FIFO rejects a write even when
  // a read is accepted in the same cycle, and an empty one rejects the read.
  assign w_wr_acc    = wrreq_i && !r_full;
  assign w_rd_acc    = rdreq_i && !w_empty;
  assign w_rdptr_nxt = w_rd_acc ? r_rdptr + AWIDTH'(1) : r_rdptr;
  assign w_usedw_nxt = UW'(usedw_next(32'(r_usedw), w_wr_acc, w_rd_acc));

  // Pointers, occupancy and the flags derived from the next occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wrptr        <= '0;
      r_rdptr        <= '0;
      r_usedw        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wrptr <= r_wrptr + AWIDTH'(1);
      r_rdptr        <= w_rdptr_nxt;
      r_usedw        <= w_usedw_nxt;
      r_full         <= (w_usedw_nxt == UW'(DEPTH));
      r_almost_full  <= (w_usedw_nxt >= UW'(ALMOST_FULL));
      r_almost_empty <= (w_usedw_nxt < UW'(ALMOST_EMPTY));
    end
  end

`ifdef FIFO_SYNC_SHOWAHEAD_EN
  // Prefetch: the RAM always fetches the word that will be at the head next cycle.
  assign w_rdpntr = w_rdptr_nxt;

  logic r_valid;

  // The prefetched word is trustworthy only if it was already in the RAM before this edge,
  // i.e. some word survives this cycle's read without counting this cycle's write
  // (the RAM has no write-to-read bypass).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_valid <= 1'b0;
    else          r_valid <= ((r_usedw - UW'(w_rd_acc)) != '0);
  end

  assign w_empty = !r_valid;
  assign q_o     = r_valid ? w_ram_q : '0;
`else
  assign w_rdpntr = r_rdptr;

  logic              r_empty;
  logic              r_rd_acc_d;
  logic [DWIDTH-1:0] r_q_hold;

  // Empty flag and the hold register that keeps q_o steady between accepted reads,
  // since the RAM output register reloads every cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_empty    <= 1'b1;
      r_rd_acc_d <= 1'b0;
      r_q_hold   <= '0;
    end else begin
      r_empty    <= (w_usedw_nxt == '0);
      r_rd_acc_d <= w_rd_acc;
      r_q_hold   <= q_o;
    end
  end

  assign w_empty = r_empty;
  assign q_o     = r_rd_acc_d ? w_ram_q : r_q_hold;
`endif

  ram_memory #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk    (clk_i),
    .data   (data_i),
    .wren   (w_wr_acc),
    .wrpntr (r_wrptr),
    .rdpntr (w_rdpntr),
    .q      (w_ram_q)
  );

  assign empty_o        = w_empty;
  assign full_o         = r_full;
  assign usedw_o        = r_usedw;
  assign almost_full_o  = r_almost_full;
  assign almost_empty_o = r_almost_empty;

endmodule
